// File: rtl/gen_elastic_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gen_elastic_pipe_pkg
// Description : Shared constants and helpers for the elastic pipeline block.
// Revision    : 1.0 - initial release
// ============================================================================
package gen_elastic_pipe_pkg;

    // Legal depth range of the pipe
    localparam int c_MIN_STAGES = 1;
    localparam int c_MAX_STAGES = 8;

    // Width needed to count 0..stages inclusive
    function automatic int cnt_width(input int stages);
        return $clog2(stages + 1);
    endfunction

    // True when a requested depth is inside the supported range
    function automatic bit stages_legal(input int stages);
        return (stages >= c_MIN_STAGES) && (stages <= c_MAX_STAGES);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gen_pipe_slice.sv
`default_nettype none
// ============================================================================
// Module      : gen_pipe_slice
// Description : One data/valid register pair of the elastic pipe. Loads on
//               enable, reloads def_val on flush, clears asynchronously.
// Revision    : 1.0 - initial release
// ============================================================================
module gen_pipe_slice #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          load_en,
    input  logic          in_vld,
    input  logic [DW-1:0] in_data,
    input  logic [DW-1:0] def_val,
    output logic          vld,
    output logic [DW-1:0] data
);

    logic          r_vld;
    logic [DW-1:0] r_data;

    // Valid bit: cleared by reset/flush, follows upstream valid when loading
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld <= 1'b0;
        end else if (flush) begin
            r_vld <= 1'b0;
        end else if (load_en) begin
            r_vld <= in_vld;
        end
    end

    // Payload: only overwritten by a real word, so empty slots keep stale data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
        end else if (flush) begin
            r_data <= def_val;
        end else if (load_en && in_vld) begin
            r_data <= in_data;
        end
    end

    assign vld  = r_vld;
    assign data = r_data;

endmodule
`default_nettype wire

// File: rtl/gen_elastic_pipe.sv
`default_nettype none
// ============================================================================
// Module      : gen_elastic_pipe
// Description : Parametrised elastic pipeline register with valid/ready
//               handshake, bubble collapsing, hold, flush and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module gen_elastic_pipe
    import gen_elastic_pipe_pkg::*;
#(
    parameter int DW     = 32,
    parameter int STAGES = 2,
    parameter int CW     = cnt_width(STAGES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          hold_en,
    input  logic [DW-1:0] def_val,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [CW-1:0] count
);

    logic [STAGES-1:0] w_vld;
    logic [STAGES-1:0] w_rdy;
    logic [STAGES-1:0] w_load;
    logic [DW-1:0]     w_data [STAGES];
    logic              w_in_fire;
    logic              w_out_fire;
    logic [CW-1:0]     r_count;

    // Ready chain from the output back: a stage moves if empty or its successor moves
    always_comb begin
        w_rdy = '0;
        w_rdy[STAGES-1] = out_ready | ~w_vld[STAGES-1];
        for (int i = STAGES - 2; i >= 0; i--) begin
            w_rdy[i] = w_rdy[i+1] | ~w_vld[i];
        end
    end

    // Hold freezes every slice; flush priority is resolved inside the slice
    assign w_load = w_rdy & {STAGES{~hold_en}};

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic          w_src_vld;
        logic [DW-1:0] w_src_data;

        if (g == 0) begin : g_head
            assign w_src_vld  = in_valid;
            assign w_src_data = in_data;
        end else begin : g_body
            assign w_src_vld  = w_vld[g-1];
            assign w_src_data = w_data[g-1];
        end

        gen_pipe_slice #(
            .DW (DW)
        ) u_slice (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .load_en (w_load[g]),
            .in_vld  (w_src_vld),
            .in_data (w_src_data),
            .def_val (def_val),
            .vld     (w_vld[g]),
            .data    (w_data[g])
        );
    end

    assign in_ready   = w_rdy[0] & ~hold_en & ~flush;
    assign out_valid  = w_vld[STAGES-1] & ~hold_en & ~flush;
    assign out_data   = w_data[STAGES-1];
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // Occupancy: up on accept, down on delivery, unchanged when both or neither
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (w_in_fire && !w_out_fire) begin
            r_count <= r_count + CW'(1);
        end else if (!w_in_fire && w_out_fire) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_gen_elastic_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_gen_elastic_pipe
// Description : Self-checking bench: directed scenarios with literal
//               expectations, then randomized traffic against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gen_elastic_pipe;

    localparam int DW = 32;
    localparam int S  = 3;
    localparam int CW = $clog2(S + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          hold_en = 1'b0;
    logic [DW-1:0] def_val = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_pass   = 0;

    gen_elastic_pipe #(
        .DW     (DW),
        .STAGES (S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .hold_en   (hold_en),
        .def_val   (def_val),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Drive one cycle's inputs, then move to the sampling point (falling edge)
    task automatic cyc(input logic iv, input logic [DW-1:0] id, input logic ordy,
                       input logic hl, input logic fl, input logic [DW-1:0] dv);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        hold_en   = hl;
        flush     = fl;
        def_val   = dv;
        @(negedge clk);
    endtask

    // Cross the active edge and settle just after it
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Reference model: words in arrival order, each with its stage position
    typedef struct {
        logic [DW-1:0] d;
        int            p;
    } ent_t;

    ent_t q[$];

    logic [DW-1:0] sw [4];
    int acc, pop, exp_cnt;

    initial begin
        sw[0] = 32'h11; sw[1] = 32'h22; sw[2] = 32'h33; sw[3] = 32'h44;

        // ---------------- reset / idle ----------------
        @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_count", count, 0);
        chk("idle_out_data", out_data, 0);
        adv();

        // ---------------- streaming ----------------
        for (int k = 0; k < 10; k++) begin
            cyc(k < 4, sw[k % 4], 1, 0, 0, 0);
            acc = (k < 4) ? k : 4;
            pop = (k - 3 < 0) ? 0 : ((k - 3 > 4) ? 4 : k - 3);
            exp_cnt = acc - pop;
            chk("stream_in_ready", in_ready, 1);
            chk("stream_count", count, exp_cnt);
            chk("stream_out_valid", out_valid, (k >= 3 && k <= 6));
            if (k >= 3 && k <= 6) chk("stream_out_data", out_data, sw[k-3]);
            adv();
        end

        // ---------------- back-pressure ----------------
        cyc(1, 32'hA1, 0, 0, 0, 0); chk("bp_c0_rdy", in_ready, 1); adv();
        cyc(1, 32'hA2, 0, 0, 0, 0); chk("bp_c1_cnt", count, 1); adv();
        cyc(1, 32'hA3, 0, 0, 0, 0); chk("bp_c2_cnt", count, 2); adv();
        cyc(1, 32'hA4, 0, 0, 0, 0);
        chk("bp_full_cnt", count, 3);
        chk("bp_full_rdy", in_ready, 0);
        chk("bp_full_ov", out_valid, 1);
        adv();
        cyc(1, 32'hA4, 1, 0, 0, 0);
        chk("bp_both_rdy", in_ready, 1);
        chk("bp_both_data", out_data, 32'hA1);
        chk("bp_both_cnt", count, 3);
        adv();
        cyc(0, 0, 1, 0, 0, 0); chk("bp_d1_data", out_data, 32'hA2); chk("bp_d1_cnt", count, 3); adv();
        cyc(0, 0, 1, 0, 0, 0); chk("bp_d2_data", out_data, 32'hA3); chk("bp_d2_cnt", count, 2); adv();
        cyc(0, 0, 1, 0, 0, 0); chk("bp_d3_data", out_data, 32'hA4); chk("bp_d3_ov", out_valid, 1); adv();
        cyc(0, 0, 1, 0, 0, 0); chk("bp_empty_ov", out_valid, 0); chk("bp_empty_cnt", count, 0); adv();

        // ---------------- bubble collapse ----------------
        cyc(1, 32'hB1, 0, 0, 0, 0); adv();
        cyc(0, 0, 0, 0, 0, 0); adv();
        cyc(0, 0, 0, 0, 0, 0); adv();
        cyc(1, 32'hB2, 0, 0, 0, 0); chk("bub_push_rdy", in_ready, 1); adv();
        cyc(0, 0, 0, 0, 0, 0); adv();
        cyc(0, 0, 0, 0, 0, 0);
        chk("bub_count", count, 2);
        chk("bub_in_ready", in_ready, 1);
        chk("bub_out_data", out_data, 32'hB1);
        adv();

        // ---------------- hold then flush ----------------
        for (int k = 0; k < 3; k++) begin
            cyc(1, 32'h55, 1, 1, 0, 0);
            chk("hold_ov", out_valid, 0);
            chk("hold_rdy", in_ready, 0);
            chk("hold_cnt", count, 2);
            chk("hold_data", out_data, 32'hB1);
            adv();
        end
        cyc(1, 32'h66, 1, 1, 1, 32'hDEADBEEF);
        chk("flush_ov", out_valid, 0);
        chk("flush_rdy", in_ready, 0);
        adv();
        cyc(0, 0, 0, 0, 0, 0);
        chk("postflush_cnt", count, 0);
        chk("postflush_ov", out_valid, 0);
        chk("postflush_data", out_data, 32'hDEADBEEF);
        chk("postflush_rdy", in_ready, 1);
        adv();

        // ---------------- async reset mid-stream ----------------
        cyc(1, 32'hC1, 0, 0, 0, 0); adv();
        cyc(1, 32'hC2, 0, 0, 0, 0); adv();
        cyc(0, 0, 0, 0, 0, 0);
        chk("arst_pre_cnt", count, 2);
        #2 rst = 1'b0;
        #1;
        chk("arst_cnt", count, 0);
        chk("arst_ov", out_valid, 0);
        chk("arst_data", out_data, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // ---------------- randomized traffic vs model ----------------
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            logic          r_iv, r_od, r_hl, r_fl, rdy0, e_ov;
            logic [DW-1:0] r_id, r_dv;
            int            np [S];
            int            lim;
            r_fl = ($urandom_range(0, 39) == 0);
            r_hl = ($urandom_range(0, 9) == 0);
            r_iv = ($urandom_range(0, 2) != 0);
            r_od = ($urandom_range(0, 3) != 0);
            r_id = $urandom;
            r_dv = $urandom;
            cyc(r_iv, r_id, r_od, r_hl, r_fl, r_dv);

            // Where each held word would sit after a free-running edge
            lim = S;
            foreach (q[j]) begin
                if (q[j].p == S - 1) np[j] = r_od ? S : S - 1;
                else                 np[j] = (q[j].p + 1 < lim - 1) ? q[j].p + 1 : lim - 1;
                lim = np[j];
            end
            rdy0 = (q.size() == 0) || (np[q.size()-1] != 0);
            e_ov = (q.size() > 0) && (q[0].p == S - 1) && !r_hl && !r_fl;

            chk("rnd_in_ready", in_ready, rdy0 && !r_hl && !r_fl);
            chk("rnd_out_valid", out_valid, e_ov);
            chk("rnd_count", count, q.size());
            if (e_ov) chk("rnd_out_data", out_data, q[0].d);

            adv();
            if (r_fl) begin
                q.delete();
            end else if (!r_hl) begin
                foreach (q[j]) q[j].p = np[j];
                if (q.size() > 0 && q[0].p == S) q.pop_front();
                if (r_iv && rdy0) q.push_back('{d: r_id, p: 0});
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
